// File: rtl/gpio_pkg.sv
// Shared register map and address-phase types for the AHB3-Lite GPIO block.
package gpio_pkg;

  localparam logic [3:0] GPIO_DOUT    = 4'h0;
  localparam logic [3:0] GPIO_DIN     = 4'h1;
  localparam logic [3:0] GPIO_DIR     = 4'h2;
  localparam logic [3:0] GPIO_SET     = 4'h3;
  localparam logic [3:0] GPIO_CLR     = 4'h4;
  localparam logic [3:0] GPIO_RISE_EN = 4'h5;
  localparam logic [3:0] GPIO_FALL_EN = 4'h6;
  localparam logic [3:0] GPIO_STATUS  = 4'h7;

  typedef enum logic [3:0] {
    REG_DOUT    = GPIO_DOUT,
    REG_DIN     = GPIO_DIN,
    REG_DIR     = GPIO_DIR,
    REG_SET     = GPIO_SET,
    REG_CLR     = GPIO_CLR,
    REG_RISE_EN = GPIO_RISE_EN,
    REG_FALL_EN = GPIO_FALL_EN,
    REG_STATUS  = GPIO_STATUS
  } gpio_reg_e;

  typedef struct packed {
    logic [3:0] idx;
    logic       write;
    logic       valid;
  } gpio_aphase_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchronizer with a trailing "prev" flop for edge detection.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/ahb3lite_gpio.sv
// AHB3-Lite GPIO slave: output/direction regs, atomic set/clear, synchronized
// inputs and per-bit edge capture into a level IRQ.
module ahb3lite_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             PORESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  input  logic [WIDTH-1:0] GPIO_I,
  output logic [WIDTH-1:0] GPIO_O,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  gpio_aphase_t     ap;
  logic [WIDTH-1:0] dout_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [WIDTH-1:0] din, rise, fall, wdata, w1c;
  logic             wr_en;
  logic             unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (CLK),
    .rst_n    (PORESETn),
    .async_in (GPIO_I),
    .sync     (din),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      ap <= '0;
    end else begin
      ap.valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        ap.idx   <= HADDR[5:2];
        ap.write <= HWRITE;
      end
    end
  end

  assign wr_en = ap.valid & ap.write;
  assign wdata = HWDATA[WIDTH-1:0];
  assign w1c   = (wr_en && ap.idx == REG_STATUS) ? wdata : '0;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      dout_q    <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (ap.idx)
        REG_DOUT:    dout_q    <= wdata;
        REG_DIR:     oe_q      <= wdata;
        REG_SET:     dout_q    <= dout_q | wdata;
        REG_CLR:     dout_q    <= dout_q & ~wdata;
        REG_RISE_EN: rise_en_q <= wdata;
        REG_FALL_EN: fall_en_q <= wdata;
        default: ;
      endcase
    end
  end

  // A fresh enabled edge outranks a simultaneous W1C of the same bit.
  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) status_q <= '0;
    else           status_q <= (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    HRDATA = '0;
    if (ap.valid && !ap.write) begin
      case (ap.idx)
        REG_DOUT:    HRDATA[WIDTH-1:0] = dout_q;
        REG_DIN:     HRDATA[WIDTH-1:0] = din;
        REG_DIR:     HRDATA[WIDTH-1:0] = oe_q;
        REG_RISE_EN: HRDATA[WIDTH-1:0] = rise_en_q;
        REG_FALL_EN: HRDATA[WIDTH-1:0] = fall_en_q;
        REG_STATUS:  HRDATA[WIDTH-1:0] = status_q;
        default: ;
      endcase
    end
  end

  assign GPIO_O    = dout_q;
  assign GPIO_OE   = oe_q;
  assign IRQ       = |status_q;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb3lite_gpio.sv
// Directed bench for ahb3lite_gpio: cycle-level reference model plus literal checks.
module tb_ahb3lite_gpio;

  localparam int W = 8;
  localparam int S = 2;

  logic          CLK = 1'b0;
  logic          PORESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = '0;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'b010;
  logic [31:0]   HWDATA = '0;
  logic          HREADY = 1'b1;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [W-1:0]  GPIO_I = '0;
  logic [W-1:0]  GPIO_O;
  logic [W-1:0]  GPIO_OE;
  logic          IRQ;

  always #5 CLK = ~CLK;

  ahb3lite_gpio #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .CLK       (CLK),
    .PORESETn  (PORESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .GPIO_I    (GPIO_I),
    .GPIO_O    (GPIO_O),
    .GPIO_OE   (GPIO_OE),
    .IRQ       (IRQ)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus a record of pad values by age.
  logic [W-1:0] m_dout, m_oe, m_ren, m_fen, m_stat;
  logic [W-1:0] pin_age [0:S];   // pin_age[k]: pad value sampled k+1 edges ago
  logic         m_valid, m_write;
  logic [5:0]   m_off;
  logic [W-1:0] m_din, m_prev, m_w1c, m_wd;

  assign m_din  = pin_age[S-1];
  assign m_prev = pin_age[S];
  assign m_wd   = HWDATA[W-1:0];
  assign m_w1c  = (m_valid && m_write && m_off == 6'h1C) ? m_wd : '0;

  always @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      m_dout <= '0; m_oe <= '0; m_ren <= '0; m_fen <= '0; m_stat <= '0;
      for (int k = 0; k <= S; k++) pin_age[k] <= '0;
      m_valid <= 1'b0; m_write <= 1'b0; m_off <= '0;
    end else begin
      if (m_valid && m_write) begin
        case (m_off)
          6'h00: m_dout <= m_wd;
          6'h08: m_oe   <= m_wd;
          6'h0C: m_dout <= m_dout | m_wd;
          6'h10: m_dout <= m_dout & ~m_wd;
          6'h14: m_ren  <= m_wd;
          6'h18: m_fen  <= m_wd;
          default: ;
        endcase
      end
      m_stat <= (m_stat & ~m_w1c) | (m_din & ~m_prev & m_ren) | (~m_din & m_prev & m_fen);
      for (int k = S; k > 0; k--) pin_age[k] <= pin_age[k-1];
      pin_age[0] <= GPIO_I;
      m_valid <= HSEL && HREADY && HTRANS[1];
      m_write <= HWRITE;
      m_off   <= {HADDR[5:2], 2'b00};
    end
  end

  function automatic logic [31:0] exp_rdata();
    if (!(m_valid && !m_write)) return '0;
    case (m_off)
      6'h00:   return 32'(m_dout);
      6'h04:   return 32'(m_din);
      6'h08:   return 32'(m_oe);
      6'h14:   return 32'(m_ren);
      6'h18:   return 32'(m_fen);
      6'h1C:   return 32'(m_stat);
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] gpo_seq [$];
  logic [W-1:0] gpo_last = '0;

  initial begin
    forever begin
      @(negedge CLK);
      check("gpio_o", GPIO_O, m_dout);
      check("gpio_oe", GPIO_OE, m_oe);
      check("irq", IRQ, m_stat != '0);
      check("hrdata", HRDATA, exp_rdata());
      check("hreadyout", HREADYOUT, 1'b1);
      check("hresp", HRESP, 1'b0);
      if (GPIO_O !== gpo_last) begin
        gpo_seq.push_back(GPIO_O);
        gpo_last = GPIO_O;
      end
    end
  end

  logic [31:0] pend_wd = '0;

  task automatic addr_phase(input logic sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd);
    @(negedge CLK); #1;
    HSEL   = sel;
    HTRANS = sel ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = addr;
    HWDATA = pend_wd;
    pend_wd = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) addr_phase(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    addr_phase(1'b1, 1'b1, addr, d);
  endtask

  task automatic rd_lit(input string name, input logic [31:0] addr, input logic [31:0] exp);
    addr_phase(1'b1, 1'b0, addr, 32'h0);
    idle(1);
    check(name, HRDATA, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] gpo_exp [3] = '{8'hA5, 8'hA7, 8'h27};

  initial begin
    GPIO_I = 8'h5A;
    repeat (6) begin
      @(negedge CLK); #1;
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 3));
      HWRITE = 1'($urandom_range(0, 1));
      HREADY = 1'($urandom_range(0, 1));
      HADDR  = $urandom;
      HWDATA = $urandom;
    end
    check("rst_gpio_o", GPIO_O, 8'h00);
    check("rst_gpio_oe", GPIO_OE, 8'h00);
    check("rst_irq", IRQ, 1'b0);
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp", HRESP, 1'b0);
    check("rst_hrdata", HRDATA, 32'h0);

    @(negedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HADDR = '0; HWDATA = '0;
    pend_wd = '0;
    PORESETn = 1'b1;
    for (int i = 0; i < 16; i++)
      rd_lit("post_reset_read", 32'(i * 4), (i == 1) ? 32'h5A : 32'h0);

    GPIO_I = 8'h00;
    idle(4);
    gpo_seq.delete();
    wr(32'h00, 32'hA5);
    wr(32'h08, 32'hFF);
    wr(32'h0C, 32'h02);
    wr(32'h10, 32'h80);
    rd_lit("dout_back_to_back", 32'h00, 32'h27);
    rd_lit("set_reads_zero", 32'h0C, 32'h0);
    check("oe_value", GPIO_OE, 8'hFF);
    check("gpo_seq_len", gpo_seq.size(), 3);
    for (int i = 0; i < 3; i++)
      check("gpo_seq", (i < gpo_seq.size()) ? 32'(gpo_seq[i]) : 32'hDEAD, 32'(gpo_exp[i]));

    addr_phase(1'b1, 1'b0, 32'h04, 32'h0);
    GPIO_I = 8'h3C;
    addr_phase(1'b1, 1'b0, 32'h04, 32'h0);
    check("din_after_1_edge", HRDATA, 32'h00);
    idle(1);
    check("din_after_2_edges", HRDATA, 32'h3C);
    wr(32'h04, 32'hFF);
    rd_lit("din_read_only", 32'h04, 32'h3C);
    rd_lit("hole_0x24", 32'h24, 32'h0);

    wr(32'h14, 32'h01);
    wr(32'h18, 32'h02);
    GPIO_I = 8'h02;
    idle(4);
    check("no_irq_disabled", IRQ, 1'b0);
    GPIO_I = 8'h01;
    idle(2);
    check("irq_2_edges", IRQ, 1'b0);
    idle(1);
    check("irq_3_edges", IRQ, 1'b1);
    rd_lit("status_both", 32'h1C, 32'h03);
    wr(32'h1C, 32'h01);
    rd_lit("status_w1c_bit0", 32'h1C, 32'h02);
    check("irq_still_high", IRQ, 1'b1);
    wr(32'h1C, 32'h02);
    rd_lit("status_w1c_bit1", 32'h1C, 32'h00);
    check("irq_cleared", IRQ, 1'b0);

    GPIO_I = 8'h00;
    idle(4);
    GPIO_I = 8'h01;
    wr(32'h1C, 32'h01);
    rd_lit("edge_beats_w1c", 32'h1C, 32'h01);
    wr(32'h1C, 32'h01);
    idle(1);
    GPIO_I = 8'h05;
    idle(4);
    GPIO_I = 8'h01;
    idle(4);
    rd_lit("bit2_disabled", 32'h1C, 32'h00);
    GPIO_I = 8'h03;
    idle(4);
    GPIO_I = 8'h01;
    idle(4);
    wr(32'h18, 32'h00);
    rd_lit("enable_clear_keeps", 32'h1C, 32'h02);
    check("irq_kept", IRQ, 1'b1);

    wr(32'h00, 32'h55);
    @(negedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = pend_wd; pend_wd = '0;
    #1 PORESETn = 1'b0;
    #1;
    check("midreset_gpio_o", GPIO_O, 8'h00);
    check("midreset_gpio_oe", GPIO_OE, 8'h00);
    check("midreset_irq", IRQ, 1'b0);
    check("midreset_hrdata", HRDATA, 32'h0);
    idle(2);
    @(negedge CLK); #1;
    PORESETn = 1'b1;
    rd_lit("midreset_dout", 32'h00, 32'h0);
    rd_lit("midreset_oe", 32'h08, 32'h0);
    rd_lit("midreset_rise_en", 32'h14, 32'h0);
    rd_lit("midreset_status", 32'h1C, 32'h0);
    rd_lit("midreset_din", 32'h04, 32'h01);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
